// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: walks every address, reads through the ECC detector,
// writes back single-bit corrections and logs double-bit / self-check events.
module ecc_scrub_ctrl #(
    parameter int unsigned DATA_WIDTH     = 138,
    parameter int unsigned PARITY_WIDTH   = 9,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned INTERVAL_WIDTH = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      scrub_en_i,
    input  logic [INTERVAL_WIDTH-1:0] scrub_interval_i,
    input  logic                      fault_detc_en_cfg_i,
    input  logic                      cnt_clr_i,
    input  logic                      func_busy_i,
    output logic                      mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]     det_data_out_i,
    input  logic                      det_sbit_err_i,
    input  logic                      det_dbit_err_i,
    input  logic                      det_ecc_fault_i,
    output logic                      det_fault_detc_en_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic [PARITY_WIDTH-1:0]   wb_parity_i,
    output logic                      mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]     mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wr_data_o,
    output logic [PARITY_WIDTH-1:0]   mem_wr_parity_o,
    output logic [CNT_WIDTH-1:0]      sbit_cnt_o,
    output logic [CNT_WIDTH-1:0]      dbit_cnt_o,
    output logic [CNT_WIDTH-1:0]      fault_cnt_o,
    output logic [ADDR_WIDTH-1:0]     err_addr_o,
    output logic                      dbit_irq_o,
    output logic                      fault_irq_o,
    output logic                      pass_done_o,
    output logic                      scrub_busy_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    logic [2:0]                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [INTERVAL_WIDTH-1:0] wait_q, wait_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [CNT_WIDTH-1:0]      sbit_q, sbit_d;
    logic [CNT_WIDTH-1:0]      dbit_q, dbit_d;
    logic [CNT_WIDTH-1:0]      fault_q, fault_d;
    logic [ADDR_WIDTH-1:0]     err_addr_q, err_addr_d;
    logic                      dbit_irq_q, dbit_irq_d;
    logic                      fault_irq_q, fault_irq_d;
    logic                      pass_done_q, pass_done_d;
    logic                      fdet_q;
    logic                      advance;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wait_q      <= '0;
            wb_data_q   <= '0;
            sbit_q      <= '0;
            dbit_q      <= '0;
            fault_q     <= '0;
            err_addr_q  <= '0;
            dbit_irq_q  <= 1'b0;
            fault_irq_q <= 1'b0;
            pass_done_q <= 1'b0;
            fdet_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wait_q      <= wait_d;
            wb_data_q   <= wb_data_d;
            sbit_q      <= sbit_d;
            dbit_q      <= dbit_d;
            fault_q     <= fault_d;
            err_addr_q  <= err_addr_d;
            dbit_irq_q  <= dbit_irq_d;
            fault_irq_q <= fault_irq_d;
            pass_done_q <= pass_done_d;
            fdet_q      <= fault_detc_en_cfg_i;
        end
    end

    // Strobes are decoded against func_busy in the same cycle so the scrubber
    // never collides with a functional access.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wait_d      = wait_q;
        wb_data_d   = wb_data_q;
        sbit_d      = sbit_q;
        dbit_d      = dbit_q;
        fault_d     = fault_q;
        err_addr_d  = err_addr_q;
        dbit_irq_d  = 1'b0;
        fault_irq_d = 1'b0;
        pass_done_d = 1'b0;
        advance     = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scrub_en_i) begin
                    state_d = ST_WAIT;
                    wait_d  = scrub_interval_i;
                end
            end
            ST_WAIT: begin
                if (!scrub_en_i) begin
                    state_d = ST_IDLE;
                end else if (wait_q == '0) begin
                    state_d = ST_READ;
                end else begin
                    wait_d = wait_q - INTERVAL_WIDTH'(1);
                end
            end
            ST_READ: begin
                if (!scrub_en_i) begin
                    state_d = ST_IDLE;
                end else if (!func_busy_i) begin
                    mem_rd_en_o = 1'b1;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (det_ecc_fault_i) begin
                    fault_d     = sat_inc(fault_q);
                    err_addr_d  = addr_q;
                    fault_irq_d = 1'b1;
                    advance     = 1'b1;
                end else if (det_dbit_err_i) begin
                    dbit_d     = sat_inc(dbit_q);
                    err_addr_d = addr_q;
                    dbit_irq_d = 1'b1;
                    advance    = 1'b1;
                end else if (det_sbit_err_i) begin
                    sbit_d    = sat_inc(sbit_q);
                    wb_data_d = det_data_out_i;
                    state_d   = ST_WB;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_WB: begin
                if (!func_busy_i) begin
                    mem_wr_en_o = 1'b1;
                    advance     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (addr_q == LAST_ADDR) begin
                addr_d      = '0;
                pass_done_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
            if (scrub_en_i) begin
                state_d = ST_WAIT;
                wait_d  = scrub_interval_i;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (cnt_clr_i) begin
            sbit_d  = '0;
            dbit_d  = '0;
            fault_d = '0;
        end
    end

    assign mem_rd_addr_o       = addr_q;
    assign mem_wr_addr_o       = addr_q;
    assign wb_data_o           = wb_data_q;
    assign mem_wr_data_o       = wb_data_q;
    assign mem_wr_parity_o     = wb_parity_i;
    assign det_fault_detc_en_o = fdet_q;
    assign sbit_cnt_o          = sbit_q;
    assign dbit_cnt_o          = dbit_q;
    assign fault_cnt_o         = fault_q;
    assign err_addr_o          = err_addr_q;
    assign dbit_irq_o          = dbit_irq_q;
    assign fault_irq_o         = fault_irq_q;
    assign pass_done_o         = pass_done_q;
    assign scrub_busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: 4-entry memory model behind a scripted
// detector, with event logs checked against hand-derived cycle numbers.
module tb_ecc_scrub_ctrl;

    localparam int unsigned DW = 138;
    localparam int unsigned PW = 9;
    localparam int unsigned AW = 8;
    localparam int unsigned IW = 16;
    localparam int unsigned CW = 2;
    localparam logic [DW-1:0] PAT = {2'b01, {17{8'h5A}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scrub_en = 1'b0;
    logic [IW-1:0] interval = '0;
    logic          cfg = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          func_busy = 1'b0;
    logic          mem_rd_en, mem_wr_en, det_fden;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr, err_addr;
    logic [DW-1:0] det_data, wb_data, mem_wr_data;
    logic          det_sbit, det_dbit, det_fault;
    logic [PW-1:0] wb_parity, mem_wr_parity;
    logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
    logic          dbit_irq, fault_irq, pass_done, scrub_busy;

    logic [3:0]    sbit_map = '0, dbit_map = '0, fault_map = '0;
    logic          rd_vld;
    logic [1:0]    rd_a;
    int            cyc = 0;
    int            n_chk = 0, n_pass = 0;
    int            viol = 0;
    int            c0, c1;

    int            rd_cyc[$], wr_cyc[$], pd_cyc[$], dirq_cyc[$], firq_cyc[$];
    logic [AW-1:0] rd_addr[$], wr_addr[$];
    logic [DW-1:0] wr_data[$];
    logic [PW-1:0] wr_par[$];

    ecc_scrub_ctrl #(
        .DATA_WIDTH(DW), .PARITY_WIDTH(PW), .ADDR_WIDTH(AW), .DEPTH(4),
        .INTERVAL_WIDTH(IW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .scrub_en_i(scrub_en), .scrub_interval_i(interval),
        .fault_detc_en_cfg_i(cfg), .cnt_clr_i(cnt_clr), .func_busy_i(func_busy),
        .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr),
        .det_data_out_i(det_data), .det_sbit_err_i(det_sbit),
        .det_dbit_err_i(det_dbit), .det_ecc_fault_i(det_fault),
        .det_fault_detc_en_o(det_fden), .wb_data_o(wb_data), .wb_parity_i(wb_parity),
        .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr),
        .mem_wr_data_o(mem_wr_data), .mem_wr_parity_o(mem_wr_parity),
        .sbit_cnt_o(sbit_cnt), .dbit_cnt_o(dbit_cnt), .fault_cnt_o(fault_cnt),
        .err_addr_o(err_addr), .dbit_irq_o(dbit_irq), .fault_irq_o(fault_irq),
        .pass_done_o(pass_done), .scrub_busy_o(scrub_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory + detector model: flags for the address read one cycle earlier.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_a   <= 2'd0;
        end else begin
            rd_vld <= mem_rd_en;
            rd_a   <= mem_rd_addr[1:0];
        end
    end
    assign det_sbit  = rd_vld & sbit_map[rd_a];
    assign det_dbit  = rd_vld & dbit_map[rd_a];
    assign det_fault = rd_vld & fault_map[rd_a];
    assign det_data  = rd_vld ? PAT : '0;
    assign wb_parity = wb_data[8:0] ^ wb_data[137:129];

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(mem_rd_addr);
            end
            if (mem_wr_en) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(mem_wr_addr);
                wr_data.push_back(mem_wr_data);
                wr_par.push_back(mem_wr_parity);
            end
            if (pass_done) pd_cyc.push_back(cyc);
            if (dbit_irq)  dirq_cyc.push_back(cyc);
            if (fault_irq) firq_cyc.push_back(cyc);
            if (func_busy && (mem_rd_en || mem_wr_en)) viol <= viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int evt_cnt(input int which);
        case (which)
            0:       return rd_cyc.size();
            1:       return wr_cyc.size();
            default: return pd_cyc.size();
        endcase
    endfunction

    // which: 0 reads, 1 writes, 2 pass_done pulses
    task automatic wait_evt(input int which, input int n, input int bound, input string tag);
        for (int i = 0; i < bound && evt_cnt(which) < n; i++) tick(1);
        chk(tag, evt_cnt(which), n);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        scrub_en  = 1'b0;
        interval  = 16'd2;
        cfg       = 1'b0;
        cnt_clr   = 1'b0;
        func_busy = 1'b0;
        sbit_map  = '0;
        dbit_map  = '0;
        fault_map = '0;
        rd_cyc.delete(); rd_addr.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_par.delete();
        pd_cyc.delete(); dirq_cyc.delete(); firq_cyc.delete();
        tick(2);
        viol  = 0;
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #3;
        chk("rst_strobes", {mem_rd_en, mem_wr_en, dbit_irq, fault_irq, pass_done, scrub_busy, det_fden}, 0);
        chk("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt, err_addr, mem_rd_addr}, 0);
        chk("rst_wb_data", wb_data, 0);
        @(posedge clk);
        #1;

        // Clean pass: reads every 5 cycles, wrap after addr 3.
        do_reset();
        cfg = 1'b1;
        scrub_en = 1'b1;
        c0 = cyc;
        tick(1);
        chk("fdet_en", det_fden, 1);
        wait_evt(0, 5, 60, "clean_reads");
        if (rd_cyc.size() >= 5) begin
            chk("clean_first_rd", rd_cyc[0], c0 + 4);
            for (int i = 0; i < 5; i++) chk("clean_addr", rd_addr[i], i % 4);
            for (int i = 1; i < 5; i++) chk("clean_period", rd_cyc[i] - rd_cyc[i-1], 5);
            chk("clean_pd_cnt", pd_cyc.size(), 1);
            if (pd_cyc.size() == 1) chk("clean_pd_cyc", pd_cyc[0], rd_cyc[3] + 2);
        end
        chk("clean_no_wr", wr_cyc.size(), 0);
        chk("clean_busy", scrub_busy, 1);

        // Single-bit error at addr 2: one writeback of the corrected word.
        do_reset();
        sbit_map = 4'b0100;
        scrub_en = 1'b1;
        wait_evt(2, 1, 60, "sbit_pass");
        chk("sbit_cnt", sbit_cnt, 1);
        chk("sbit_wb_data", wb_data, PAT);
        chk("sbit_wr_cnt", wr_cyc.size(), 1);
        if (wr_cyc.size() == 1 && rd_cyc.size() >= 4) begin
            chk("sbit_wr_addr", wr_addr[0], 2);
            chk("sbit_wr_data", wr_data[0], PAT);
            chk("sbit_wr_par", wr_par[0], 9'h0F7);
            chk("sbit_wr_cyc", wr_cyc[0], rd_cyc[2] + 2);
            chk("sbit_period", rd_cyc[3] - rd_cyc[2], 6);
        end
        chk("sbit_no_irq", dirq_cyc.size() + firq_cyc.size(), 0);

        // Fault and dbit together at addr 1: fault wins, nothing written.
        do_reset();
        dbit_map  = 4'b0010;
        fault_map = 4'b0010;
        scrub_en  = 1'b1;
        wait_evt(2, 1, 60, "fault_pass");
        chk("fault_cnt", fault_cnt, 1);
        chk("fault_dbit_cnt", dbit_cnt, 0);
        chk("fault_err_addr", err_addr, 1);
        chk("fault_irq_cnt", firq_cyc.size(), 1);
        if (firq_cyc.size() == 1 && rd_cyc.size() >= 2) chk("fault_irq_cyc", firq_cyc[0], rd_cyc[1] + 2);
        chk("fault_no_dirq", dirq_cyc.size(), 0);
        chk("fault_no_wr", wr_cyc.size(), 0);

        // func_busy for 3 cycles in READ and again in WB.
        do_reset();
        sbit_map = 4'b0001;
        scrub_en = 1'b1;
        c0 = cyc;
        tick(4); func_busy = 1'b1;
        tick(3); func_busy = 1'b0;
        tick(2); func_busy = 1'b1;
        tick(3); func_busy = 1'b0;
        tick(2);
        chk("busy_rd_cnt", rd_cyc.size(), 1);
        chk("busy_wr_cnt", wr_cyc.size(), 1);
        if (rd_cyc.size() >= 1) chk("busy_rd_cyc", rd_cyc[0], c0 + 7);
        if (wr_cyc.size() >= 1) chk("busy_wr_cyc", wr_cyc[0], c0 + 12);
        chk("busy_viol", viol, 0);

        // Saturation (2-bit counters) and clear colliding with an increment.
        do_reset();
        sbit_map = 4'b1111;
        scrub_en = 1'b1;
        tick(11);
        chk("pre_clr", sbit_cnt, 1);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_vs_inc", sbit_cnt, 0);
        wait_evt(1, 6, 100, "sat_writes");
        chk("sat_cnt", sbit_cnt, 3);

        // Drop scrub_en in READ of addr 1, then resume there.
        do_reset();
        scrub_en = 1'b1;
        tick(9);
        scrub_en = 1'b0;
        tick(3);
        chk("drop_rd_cnt", rd_cyc.size(), 1);
        chk("drop_idle", scrub_busy, 0);
        c1 = cyc;
        scrub_en = 1'b1;
        wait_evt(0, 2, 30, "resume_read");
        if (rd_cyc.size() >= 2) begin
            chk("resume_addr", rd_addr[1], 1);
            chk("resume_cyc", rd_cyc[1], c1 + 4);
        end

        // Asynchronous reset in the middle of a WB cycle.
        do_reset();
        sbit_map = 4'b0001;
        scrub_en = 1'b1;
        tick(6);
        #1;
        chk("wb_before_rst", mem_wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_state", scrub_busy, 0);
        chk("rst_sbit_cnt", sbit_cnt, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
